// File: rtl/reg_writeback.sv
// reg_writeback: writeback pipeline register with load extraction, misalign detection, forwarding hits and write counter.
module reg_writeback #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_load,
    input  logic [DATA_W-1:0] in_link,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [1:0]        in_off,
    input  logic [ADDR_W-1:0] fwd_ra,
    input  logic [ADDR_W-1:0] fwd_rb,
    output logic [ADDR_W-1:0] dirwrite,
    output logic [DATA_W-1:0] datawrite,
    output logic              memwrite,
    output logic              misalign,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [31:0]       wb_count
);
    logic [ADDR_W-1:0] dirwrite_q, dirwrite_d;
    logic [DATA_W-1:0] datawrite_q, datawrite_d;
    logic              memwrite_q, memwrite_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       wb_count_q, wb_count_d;
    logic              take, is_load, mis, wen;
    logic [15:0]       half;
    logic [7:0]        byte_v;
    logic [DATA_W-1:0] load_ext, result;

    always_comb begin
        take     = in_valid && !stall && !flush;
        is_load  = in_sel == 2'b01;
        mis      = is_load && ((in_size == 2'b01) ? in_off[0]
                             : (in_size == 2'b10) ? 1'b0
                             : (in_off != 2'b00));
        half     = in_off[1] ? in_load[15:0] : in_load[31:16];
        byte_v   = (in_off == 2'd0) ? in_load[31:24]
                 : (in_off == 2'd1) ? in_load[23:16]
                 : (in_off == 2'd2) ? in_load[15:8] : in_load[7:0];
        load_ext = (in_size == 2'b01) ? {{(DATA_W-16){in_signed & half[15]}}, half}
                 : (in_size == 2'b10) ? {{(DATA_W-8){in_signed & byte_v[7]}}, byte_v}
                 : in_load;
        result   = is_load ? load_ext : (in_sel == 2'b10) ? in_link : in_alu;
        wen      = take && in_regwrite && (in_dst != '0) && !mis;
        // bubbles leave the last address/data visible on the write port
        dirwrite_d  = take ? in_dst : dirwrite_q;
        datawrite_d = take ? result : datawrite_q;
        memwrite_d  = wen;
        misalign_d  = take && mis;
        wb_count_d  = wb_count_q + 32'(wen);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirwrite_q  <= '0;
            datawrite_q <= '0;
            memwrite_q  <= 1'b0;
            misalign_q  <= 1'b0;
            wb_count_q  <= '0;
        end else begin
            dirwrite_q  <= dirwrite_d;
            datawrite_q <= datawrite_d;
            memwrite_q  <= memwrite_d;
            misalign_q  <= misalign_d;
            wb_count_q  <= wb_count_d;
        end
    end

    always_comb begin
        dirwrite  = dirwrite_q;
        datawrite = datawrite_q;
        memwrite  = memwrite_q;
        misalign  = misalign_q;
        wb_count  = wb_count_q;
        fwd_a_hit = memwrite_q && (dirwrite_q == fwd_ra);
        fwd_b_hit = memwrite_q && (dirwrite_q == fwd_rb);
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vectors with hand-computed expectations for reg_writeback.
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0, in_regwrite = 1'b0;
    logic [4:0]  in_dst = '0, fwd_ra = '0, fwd_rb = '0;
    logic [1:0]  in_sel = '0, in_size = '0, in_off = '0;
    logic [31:0] in_alu = '0, in_load = '0, in_link = '0;
    logic        in_signed = 1'b0;
    logic [4:0]  dirwrite;
    logic [31:0] datawrite, wb_count;
    logic        memwrite, misalign, fwd_a_hit, fwd_b_hit;
    int checks = 0;
    int errors = 0;

    reg_writeback dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_dst(in_dst), .in_sel(in_sel),
        .in_alu(in_alu), .in_load(in_load), .in_link(in_link), .in_size(in_size),
        .in_signed(in_signed), .in_off(in_off), .fwd_ra(fwd_ra), .fwd_rb(fwd_rb),
        .dirwrite(dirwrite), .datawrite(datawrite), .memwrite(memwrite), .misalign(misalign),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] dst, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] size,
                         input logic sgn, input logic [1:0] off);
        in_valid = v; in_regwrite = rw; in_dst = dst; in_sel = sel;
        in_alu = alu; in_load = ld; in_size = size; in_signed = sgn; in_off = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_link = 32'hDEAD_BEEF;
        #2;
        check("rst_memwrite", 32'(memwrite), 0);
        check("rst_datawrite", datawrite, 0);
        check("rst_dirwrite", 32'(dirwrite), 0);
        check("rst_count", wb_count, 0);
        check("rst_fwd_a", 32'(fwd_a_hit), 0);
        check("rst_misalign", 32'(misalign), 0);
        #10 rst = 1'b0;
        drive(1, 1, 5, 2'b00, 54, 0, 0, 0, 0);
        tick();
        check("alu_dir", 32'(dirwrite), 5);
        check("alu_data", datawrite, 54);
        check("alu_we", 32'(memwrite), 1);
        check("alu_count", wb_count, 1);
        fwd_ra = 5; #1;
        check("alu_fwd_a", 32'(fwd_a_hit), 1);
        drive(0, 1, 9, 2'b00, 99, 0, 0, 0, 0);
        tick();
        check("bub_we", 32'(memwrite), 0);
        check("bub_data_hold", datawrite, 54);
        check("bub_dir_hold", 32'(dirwrite), 5);
        check("bub_fwd_a", 32'(fwd_a_hit), 0);
        drive(1, 1, 8, 2'b01, 0, 32'h1280_3456, 2'b10, 1, 2'd1);
        tick();
        check("lb_signed", datawrite, 32'hFFFF_FF80);
        check("lb_we", 32'(memwrite), 1);
        check("lb_count", wb_count, 2);
        fwd_ra = 8; fwd_rb = 5; #1;
        check("fwd_a_hit", 32'(fwd_a_hit), 1);
        check("fwd_b_hit", 32'(fwd_b_hit), 0);
        in_signed = 1'b0;
        tick();
        check("lbu", datawrite, 32'h0000_0080);
        check("lbu_count", wb_count, 3);
        drive(1, 1, 8, 2'b01, 0, 32'h1280_F456, 2'b01, 1, 2'd2);
        tick();
        check("lh_off2", datawrite, 32'hFFFF_F456);
        drive(1, 1, 8, 2'b01, 0, 32'h9280_F456, 2'b01, 0, 2'd0);
        tick();
        check("lhu_off0", datawrite, 32'h0000_9280);
        drive(1, 1, 8, 2'b01, 0, 32'hA1B2_C3D4, 2'b10, 0, 2'd3);
        tick();
        check("lbu_off3", datawrite, 32'h0000_00D4);
        drive(1, 1, 8, 2'b01, 0, 32'hA1B2_C3D4, 2'b11, 1, 2'd0);
        tick();
        check("lw_size3", datawrite, 32'hA1B2_C3D4);
        drive(1, 1, 31, 2'b10, 1, 0, 0, 0, 0);
        tick();
        check("link_data", datawrite, 32'hDEAD_BEEF);
        check("link_dir", 32'(dirwrite), 31);
        drive(1, 1, 7, 2'b11, 32'h55, 0, 0, 0, 0);
        tick();
        check("sel3_alu", datawrite, 32'h55);
        check("sel3_count", wb_count, 9);
        drive(1, 1, 8, 2'b01, 0, 32'h1234_5678, 2'b01, 1, 2'd1);
        tick();
        check("mis_h_pulse", 32'(misalign), 1);
        check("mis_h_we", 32'(memwrite), 0);
        check("mis_h_count", wb_count, 9);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("mis_one_cycle", 32'(misalign), 0);
        drive(1, 1, 8, 2'b01, 0, 32'h1234_5678, 2'b00, 0, 2'd2);
        tick();
        check("mis_w_pulse", 32'(misalign), 1);
        check("mis_w_we", 32'(memwrite), 0);
        drive(1, 1, 8, 2'b01, 0, 32'h1234_5678, 2'b10, 0, 2'd3);
        tick();
        check("byte_off3_ok", 32'(misalign), 0);
        check("byte_off3_we", 32'(memwrite), 1);
        drive(1, 1, 0, 2'b00, 77, 0, 0, 0, 0);
        tick();
        check("dst0_we", 32'(memwrite), 0);
        check("dst0_count", wb_count, 10);
        drive(1, 0, 4, 2'b00, 77, 0, 0, 0, 0);
        tick();
        check("norw_we", 32'(memwrite), 0);
        drive(1, 1, 3, 2'b00, 7, 0, 0, 0, 0);
        stall = 1'b1;
        tick();
        check("stall_we", 32'(memwrite), 0);
        check("stall_count", wb_count, 10);
        flush = 1'b1;
        tick();
        check("stall_flush_we", 32'(memwrite), 0);
        stall = 1'b0;
        tick();
        check("flush_we", 32'(memwrite), 0);
        flush = 1'b0;
        tick();
        check("resume_we", 32'(memwrite), 1);
        check("resume_data", datawrite, 7);
        check("resume_count", wb_count, 11);
        in_valid = 1'b0;
        tick();
        fwd_ra = 0; #1;
        check("fwd_bub_ra0", 32'(fwd_a_hit), 0);
        fwd_ra = 3; #1;
        check("fwd_bub_ra3", 32'(fwd_a_hit), 0);
        drive(1, 1, 6, 2'b00, 32'hCAFE, 0, 0, 0, 0);
        tick();
        check("pre_rst_we", 32'(memwrite), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_we", 32'(memwrite), 0);
        check("arst_count", wb_count, 0);
        check("arst_data", datawrite, 0);
        check("arst_dir", 32'(dirwrite), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_idle", 32'(memwrite), 0);
        tick();
        check("post_rst_we", 32'(memwrite), 1);
        check("post_rst_count", wb_count, 1);
        check("post_rst_data", datawrite, 32'hCAFE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width for the register bank write port.
REQ-002 Parameter DATA_W, default 32, data width; load-extraction rules assume 32.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall  in  1  upstream held; a bubble enters writeback.
REQ-006 flush  in  1  upstream squashed; a bubble enters writeback.
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_regwrite  in  1  entry writes a register.
REQ-009 in_dst  in  ADDR_W  destination register.
REQ-010 in_sel  in  2  result source: 00 ALU, 01 load, 10 link, 11 treated as ALU.
REQ-011 in_alu, in_load, in_link  in  DATA_W each  candidate results; in_load is the raw aligned memory word.
REQ-012 in_size  in  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-013 in_signed  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-014 in_off  in  2  byte offset of the load address.
REQ-015 dirwrite  out  ADDR_W  register bank write address.
REQ-016 datawrite  out  DATA_W  register bank write data.
REQ-017 memwrite  out  1  register bank write enable.
REQ-018 misalign  out  1  one-cycle pulse for a misaligned load.
REQ-019 fwd_ra, fwd_rb  in  ADDR_W  read addresses being issued to the register bank.
REQ-020 fwd_a_hit, fwd_b_hit  out  1  pending write matches fwd_ra / fwd_rb.
REQ-021 wb_count  out  32  count of committed register writes.

Function
REQ-022 Single pipeline register; every output except the fwd_*_hit signals is registered; latency from capture edge to memwrite is 1 cycle.
REQ-023 On each edge, if flush or stall then capture a bubble (valid=0), else capture the inputs; flush and stall together give a bubble.
REQ-024 A bubble forces memwrite=0 and misalign=0; dirwrite and datawrite hold their prior values.
REQ-025 Load extraction is big-endian: half at off 0 -> in_load[31:16], off 2 -> [15:0]; byte at off 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-026 Extracted sub-word is sign- or zero-extended to DATA_W per in_signed.
REQ-027 Misaligned load = in_sel=01 with word size and in_off!=0, or half size and in_off[0]=1.
REQ-028 A captured misaligned load sets misalign=1 for exactly one cycle with memwrite=0.
REQ-029 memwrite=1 for exactly one cycle per captured entry with valid, regwrite, in_dst!=0 and no misalignment.
REQ-030 An entry with in_dst=0 is never written and never counted.
REQ-031 wb_count increments by 1 on each edge that captures a write-qualified entry and wraps from 0xFFFFFFFF to 0.
REQ-032 fwd_a_hit = memwrite and (dirwrite==fwd_ra), combinational; fwd_b_hit likewise for fwd_rb; both are 0 when memwrite=0.

Reset
REQ-033 While rst=1 (asynchronous): register valid=0, memwrite=0, misalign=0, dirwrite=0, datawrite=0, wb_count=0, fwd_a_hit=0, fwd_b_hit=0.
REQ-034 rst arriving mid-write drops that write; the first capture occurs on the first rising edge after rst deasserts.

Verification
REQ-035 ALU write: valid, regwrite, dst=5, sel=00, alu=54 -> next cycle dirwrite=5, datawrite=54, memwrite=1 for 1 cycle, wb_count=1.
REQ-036 Signed byte load: sel=01, size=10, signed=1, off=1, load=0x1280_3456, dst=8 -> datawrite=0xFFFF_FF80; repeat with signed=0 -> 0x0000_0080.
REQ-037 Misalign and $0: half load with off=1 -> misalign pulse, memwrite=0, wb_count unchanged; ALU write with dst=0 -> memwrite=0, count unchanged.
REQ-038 Bubbles: stall=1 with a valid write -> memwrite=0 next cycle; stall=1 and flush=1 together -> bubble; stall=0 -> the next capture writes normally.
REQ-039 Forwarding: memwrite with dirwrite=8 and fwd_ra=8, fwd_rb=5 -> fwd_a_hit=1, fwd_b_hit=0; fwd_ra=0 against a bubble -> fwd_a_hit=0.
REQ-040 Async reset: assert rst between clock edges during memwrite=1 -> memwrite, wb_count and datawrite read 0 immediately, before the next edge.
